// File: rtl/rom_search_ctrl_if.sv
// Bus bundle between the search controller, the ROM macro and the display/key side.
// The controller takes the slave view; whoever drives keys and models the ROM takes master.
interface rom_search_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q;
   logic [DATA_W-1:0] result;
   logic [ADDR_W-1:0] result_addr;
   logic              busy;
   logic              finished;

   modport slave (
      input  start, mode, rom_q,
      output rom_addr, result, result_addr, busy, finished
   );

   modport master (
      output start, mode, rom_q,
      input  rom_addr, result, result_addr, busy, finished
   );
endinterface

// File: rtl/rom_search_ctrl.sv
// ROM max/min search sequencer: walks addresses 0..DEPTH-1, tracks the read
// latency with a (valid, address) shift register and keeps the best word seen.
module rom_search_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 256,
   parameter int ROM_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_a_p,
   rom_search_ctrl_if.slave    bus
);

   // Termination is an explicit compare, so DEPTH = 2^ADDR_W never relies on wrap.
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t                          state_q, state_d;
   logic [ADDR_W-1:0]               rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0]               result_q, result_d;
   logic [ADDR_W-1:0]               res_addr_q, res_addr_d;
   logic                            busy_q, busy_d;
   logic                            fin_q, fin_d;
   logic                            mode_q, mode_d;
   logic                            start_d_q;
   logic [ROM_LAT-1:0]              vld_q;
   logic [ROM_LAT-1:0][ADDR_W-1:0]  apipe_q;

   logic              start_edge;
   logic              issue;
   logic              tail_vld;
   logic [ADDR_W-1:0] tail_addr;
   logic              better;

   assign start_edge = bus.start & ~start_d_q;
   assign issue      = (state_q == SCAN);
   assign tail_vld   = vld_q[ROM_LAT-1];
   assign tail_addr  = apipe_q[ROM_LAT-1];
   // Strict compare: on ties the earlier (lower) address is kept.
   assign better     = mode_q ? (bus.rom_q < result_q) : (bus.rom_q > result_q);

   // Next-state, address counter and best-value tracking.
   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      result_d   = result_q;
      res_addr_d = res_addr_q;
      busy_d     = busy_q;
      fin_d      = fin_q;
      mode_d     = mode_q;

      // Address 0 always loads so uniform ROMs report address 0.
      if (tail_vld && (better || tail_addr == '0)) begin
         result_d   = bus.rom_q;
         res_addr_d = tail_addr;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start_edge) begin
               state_d    = SCAN;
               rom_addr_d = '0;
               mode_d     = bus.mode;
               result_d   = bus.mode ? '1 : '0;
               res_addr_d = '0;
               busy_d     = 1'b1;
               fin_d      = 1'b0;
            end
         end
         SCAN: begin
            if (rom_addr_q == LAST) state_d = DRAIN;
            else                    rom_addr_d = rom_addr_q + 1'b1;
         end
         DRAIN: begin
            if (tail_vld && tail_addr == LAST) begin
               state_d    = DONE;
               rom_addr_d = '0;
               busy_d     = 1'b0;
               fin_d      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
         state_q    <= IDLE;
         rom_addr_q <= '0;
         result_q   <= '0;
         res_addr_q <= '0;
         busy_q     <= 1'b0;
         fin_q      <= 1'b0;
         mode_q     <= 1'b0;
         start_d_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         result_q   <= result_d;
         res_addr_q <= res_addr_d;
         busy_q     <= busy_d;
         fin_q      <= fin_d;
         mode_q     <= mode_d;
         start_d_q  <= bus.start;
      end
   end

   // Read-tracking pipeline: tail lines up with rom_q for the same address.
   always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
         vld_q   <= '0;
         apipe_q <= '0;
      end else begin
         vld_q[0]   <= issue;
         apipe_q[0] <= rom_addr_q;
         for (int i = 1; i < ROM_LAT; i++) begin
            vld_q[i]   <= vld_q[i-1];
            apipe_q[i] <= apipe_q[i-1];
         end
      end
   end

   assign bus.rom_addr    = rom_addr_q;
   assign bus.result      = result_q;
   assign bus.result_addr = res_addr_q;
   assign bus.busy        = busy_q;
   assign bus.finished    = fin_q;

endmodule

// File: tb/tb_rom_search_ctrl.sv
// Directed bench: a DEPTH=256/ROM_LAT=1 instance and a DEPTH=16/ROM_LAT=2
// instance, each with a behavioural synchronous ROM of matching latency.
module tb_rom_search_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   int   e0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rom_search_ctrl_if #(.ADDR_W(8), .DATA_W(16)) if0 ();
   rom_search_ctrl_if #(.ADDR_W(4), .DATA_W(16)) if1 ();

   rom_search_ctrl #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .ROM_LAT(1)) dut0 (
      .clk(clk), .rst_a_p(rst), .bus(if0));
   rom_search_ctrl #(.ADDR_W(4), .DATA_W(16), .DEPTH(16), .ROM_LAT(2)) dut1 (
      .clk(clk), .rst_a_p(rst), .bus(if1));

   logic [15:0] mem0 [256];
   logic [15:0] mem1 [16];
   logic [15:0] q0, q1a, q1b;

   always @(posedge clk) begin
      q0  <= mem0[if0.rom_addr];
      q1a <= mem1[if1.rom_addr];
      q1b <= q1a;
   end
   assign if0.rom_q = q0;
   assign if1.rom_q = q1b;

   typedef struct {
      int          sel;
      int          pat;
      bit          md;
      logic [15:0] er;
      logic [7:0]  ea;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic fill(input int pat);
      for (int i = 0; i < 256; i++) begin
         case (pat)
            0, 4:    mem0[i] = 16'(i);
            1:       mem0[i] = 16'hFFFF;
            2:       mem0[i] = 16'h0000;
            3:       mem0[i] = 16'hFFFF;
            5:       mem0[i] = 16'h0005;
            8:       mem0[i] = 16'h1234;
            default: mem0[i] = 16'h0000;
         endcase
      end
      for (int i = 0; i < 16; i++) mem1[i] = (pat == 6) ? 16'(i) : 16'h0009;
      case (pat)
         0: mem0[8'h5A] = 16'hBEEF;
         1: begin mem0[8'h10] = 16'h0003; mem0[8'hC3] = 16'h0003; end
         5: mem0[8'hFF] = 16'h0004;
         6: mem1[15] = 16'h8000;
         7: begin mem1[3] = 16'h0001; mem1[9] = 16'h0001; end
         8: begin mem0[8'h20] = 16'h7777; mem0[8'h21] = 16'h7777; end
         default: ;
      endcase
   endtask

   // Raise start at a falling edge; the next rising edge is E0. start is left high.
   task automatic start_scan(input int sel, input bit md);
      @(negedge clk);
      if (sel == 0) begin if0.mode = md; if0.start = 1'b1; end
      else          begin if1.mode = md; if1.start = 1'b1; end
      @(posedge clk);
      #1;
      e0 = cyc;
      chk("busy_at_E0", {31'd0, (sel == 0) ? if0.busy : if1.busy}, 32'd1);
      chk("fin_at_E0", {31'd0, (sel == 0) ? if0.finished : if1.finished}, 32'd0);
   endtask

   task automatic wait_done(input int sel, output int lat);
      bit fin;
      fin = 1'b0;
      for (int n = 0; n < 2000 && !fin; n++) begin
         @(posedge clk);
         #1;
         fin = (sel == 0) ? if0.finished : if1.finished;
      end
      if (!fin) chk("done_timeout", 32'd0, 32'd1);
      lat = cyc - e0;
   endtask

   task automatic check_result(input string tag, input int sel, input logic [15:0] er,
                               input logic [7:0] ea, input int elat, input int lat);
      logic [15:0] r;
      logic [7:0]  a;
      r = (sel == 0) ? if0.result : if1.result;
      a = (sel == 0) ? if0.result_addr : {4'h0, if1.result_addr};
      chk({tag, "_result"}, {16'd0, r}, {16'd0, er});
      chk({tag, "_addr"}, {24'd0, a}, {24'd0, ea});
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_busy_low"}, {31'd0, (sel == 0) ? if0.busy : if1.busy}, 32'd0);
   endtask

   initial begin
      vec_t vecs[10];
      int   lat;
      bit   hit;

      vecs[0] = '{0, 0, 1'b0, 16'hBEEF, 8'h5A};
      vecs[1] = '{0, 1, 1'b1, 16'h0003, 8'h10};
      vecs[2] = '{0, 2, 1'b0, 16'h0000, 8'h00};
      vecs[3] = '{0, 3, 1'b1, 16'hFFFF, 8'h00};
      vecs[4] = '{0, 4, 1'b0, 16'h00FF, 8'hFF};
      vecs[5] = '{0, 4, 1'b1, 16'h0000, 8'h00};
      vecs[6] = '{0, 5, 1'b1, 16'h0004, 8'hFF};
      vecs[7] = '{0, 8, 1'b0, 16'h7777, 8'h20};
      vecs[8] = '{1, 6, 1'b0, 16'h8000, 8'h0F};
      vecs[9] = '{1, 7, 1'b1, 16'h0001, 8'h03};

      if0.start = 1'b0; if0.mode = 1'b0;
      if1.start = 1'b0; if1.mode = 1'b0;
      fill(0);

      // Reset values while reset is held across a clock edge.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, if0.busy}, 32'd0);
      chk("rst_finished", {31'd0, if0.finished}, 32'd0);
      chk("rst_rom_addr", {24'd0, if0.rom_addr}, 32'd0);
      chk("rst_result", {16'd0, if0.result}, 32'd0);
      chk("rst_result_addr", {24'd0, if0.result_addr}, 32'd0);
      chk("rst_dut1_busy", {31'd0, if1.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Table-driven scans.
      for (int v = 0; v < 10; v++) begin
         @(negedge clk);
         fill(vecs[v].pat);
         start_scan(vecs[v].sel, vecs[v].md);
         @(negedge clk);
         if (vecs[v].sel == 0) if0.start = 1'b0; else if1.start = 1'b0;
         wait_done(vecs[v].sel, lat);
         check_result($sformatf("vec%0d", v), vecs[v].sel, vecs[v].er, vecs[v].ea,
                      (vecs[v].sel == 0) ? 257 : 18, lat);
         if (vecs[v].sel == 0) chk("done_rom_addr", {24'd0, if0.rom_addr}, 32'd0);
      end

      // Edge mid-scan then start held through DONE: no retrigger.
      @(negedge clk);
      fill(0);
      start_scan(0, 1'b0);
      @(negedge clk);
      if0.start = 1'b0;
      repeat (48) @(negedge clk);
      if0.start = 1'b1;
      wait_done(0, lat);
      check_result("held", 0, 16'hBEEF, 8'h5A, 257, lat);
      repeat (20) @(posedge clk);
      #1;
      chk("held_fin_kept", {31'd0, if0.finished}, 32'd1);
      chk("held_no_restart", {31'd0, if0.busy}, 32'd0);
      chk("held_result_kept", {16'd0, if0.result}, 32'h0000BEEF);
      @(negedge clk);
      if0.start = 1'b0;
      fill(1);
      start_scan(0, 1'b1);
      @(negedge clk);
      if0.start = 1'b0;
      wait_done(0, lat);
      check_result("restart_min", 0, 16'h0003, 8'h10, 257, lat);

      // Asynchronous reset mid-scan at rom_addr 0x80.
      @(negedge clk);
      fill(0);
      start_scan(0, 1'b0);
      @(negedge clk);
      if0.start = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
         @(posedge clk);
         #1;
         hit = (if0.rom_addr == 8'h80);
      end
      chk("reach_0x80", {31'd0, hit}, 32'd1);
      chk("pre_rst_result", {16'd0, if0.result}, 32'h0000BEEF);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, if0.busy}, 32'd0);
      chk("arst_rom_addr", {24'd0, if0.rom_addr}, 32'd0);
      chk("arst_result", {16'd0, if0.result}, 32'd0);
      chk("arst_result_addr", {24'd0, if0.result_addr}, 32'd0);
      chk("arst_finished", {31'd0, if0.finished}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      start_scan(0, 1'b0);
      @(negedge clk);
      if0.start = 1'b0;
      wait_done(0, lat);
      check_result("post_rst", 0, 16'hBEEF, 8'h5A, 257, lat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

endmodule
